viewport_transform: RTL and testbench

VIEWPORT_TRANSFORM -- requirements
Module: viewport_transform

---
 rtl/viewport_transform.sv | 186 ++++++++++++++++++
 tb/tb_viewport_transform.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viewport_transform.sv
// Three-stage NDC-to-screen viewport transform with valid/ready handshake.
// Optional S3 saturation to the 320x240x256 screen box: define VIEWPORT_CLAMP_EN.
module viewport_transform (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush_in,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic [15:0]  vertex_id_in,
    input  logic [95:0]  vertex_in,
    input  logic [11:0]  color_in,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [15:0]  vertex_id_out,
    output logic [127:0] vertex_out,
    output logic [11:0]  color_out,
    output logic         clamped_out,
    output logic [15:0]  count_out
);
    localparam logic [31:0] W_ONE = 32'h0001_0000;

    logic         s1_valid_q, s1_valid_d;
    logic [15:0]  s1_id_q, s1_id_d;
    logic [95:0]  s1_pos_q, s1_pos_d;
    logic [11:0]  s1_col_q, s1_col_d;

    logic         s2_valid_q, s2_valid_d;
    logic [15:0]  s2_id_q, s2_id_d;
    logic [31:0]  s2_x_q, s2_x_d;
    logic [31:0]  s2_y_q, s2_y_d;
    logic [31:0]  s2_z_q, s2_z_d;
    logic [11:0]  s2_col_q, s2_col_d;

    logic         s3_valid_q, s3_valid_d;
    logic [15:0]  s3_id_q, s3_id_d;
    logic [127:0] s3_pos_q, s3_pos_d;
    logic [11:0]  s3_col_q, s3_col_d;
    logic         s3_clamp_q, s3_clamp_d;

    logic [15:0]  count_q, count_d;

    logic         en;
    logic         accept;
    logic [47:0]  prod_x, prod_y, prod_z;
    logic [31:0]  x_s, y_s, z_s;
    logic [31:0]  cx, cy, cz;
    logic         clamp_hit;
    logic         unused_prod;

    assign unused_prod = ^{prod_x[47:32], prod_y[47:32], prod_z[47:32]};

    always_comb begin
        en        = !s3_valid_q || ready_in;
        ready_out = en && !flush_in;
        accept    = valid_in && ready_out;

        // Only the low 32 bits of each 48-bit product are kept.
        prod_x = {{16{s1_pos_q[31]}}, s1_pos_q[31:0]} * 48'd160;
        prod_y = {{16{s1_pos_q[63]}}, s1_pos_q[63:32]} * 48'd120;
        prod_z = {{16{s1_pos_q[95]}}, s1_pos_q[95:64]} * 48'd128;
        x_s = prod_x[31:0] + 32'h00A0_0000;
        y_s = 32'h0078_0000 - prod_y[31:0];
        z_s = prod_z[31:0] + 32'h0080_0000;

`ifdef VIEWPORT_CLAMP_EN
        cx = s2_x_q;
        cy = s2_y_q;
        cz = s2_z_q;
        clamp_hit = 1'b0;
        if (s2_x_q[31]) begin
            cx = '0;
            clamp_hit = 1'b1;
        end else if ($signed(s2_x_q) > $signed(32'h013F_0000)) begin
            cx = 32'h013F_0000;
            clamp_hit = 1'b1;
        end
        if (s2_y_q[31]) begin
            cy = '0;
            clamp_hit = 1'b1;
        end else if ($signed(s2_y_q) > $signed(32'h00EF_0000)) begin
            cy = 32'h00EF_0000;
            clamp_hit = 1'b1;
        end
        if (s2_z_q[31]) begin
            cz = '0;
            clamp_hit = 1'b1;
        end else if ($signed(s2_z_q) > $signed(32'h00FF_0000)) begin
            cz = 32'h00FF_0000;
            clamp_hit = 1'b1;
        end
`else
        cx = s2_x_q;
        cy = s2_y_q;
        cz = s2_z_q;
        clamp_hit = 1'b0;
`endif

        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_pos_d   = s1_pos_q;
        s1_col_d   = s1_col_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        s2_z_d     = s2_z_q;
        s2_col_d   = s2_col_q;
        s3_valid_d = s3_valid_q;
        s3_id_d    = s3_id_q;
        s3_pos_d   = s3_pos_q;
        s3_col_d   = s3_col_q;
        s3_clamp_d = s3_clamp_q;
        count_d    = count_q;

        // Whole pipeline moves together; a stall freezes every stage.
        if (en) begin
            s1_valid_d = accept;
            s1_id_d    = vertex_id_in;
            s1_pos_d   = vertex_in;
            s1_col_d   = color_in;
            s2_valid_d = s1_valid_q;
            s2_id_d    = s1_id_q;
            s2_x_d     = x_s;
            s2_y_d     = y_s;
            s2_z_d     = z_s;
            s2_col_d   = s1_col_q;
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_id_d    = s2_id_q;
                s3_pos_d   = {W_ONE, cz, cy, cx};
                s3_col_d   = s2_col_q;
                s3_clamp_d = clamp_hit;
            end
        end

        if (flush_in) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
            count_d    = '0;
        end else if (accept) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_id_q    <= '0;
            s3_pos_q   <= '0;
            s3_col_q   <= '0;
            s3_clamp_q <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s3_id_q    <= s3_id_d;
            s3_pos_q   <= s3_pos_d;
            s3_col_q   <= s3_col_d;
            s3_clamp_q <= s3_clamp_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        s1_id_q  <= s1_id_d;
        s1_pos_q <= s1_pos_d;
        s1_col_q <= s1_col_d;
        s2_id_q  <= s2_id_d;
        s2_x_q   <= s2_x_d;
        s2_y_q   <= s2_y_d;
        s2_z_q   <= s2_z_d;
        s2_col_q <= s2_col_d;
    end

    assign valid_out     = s3_valid_q;
    assign vertex_id_out = s3_id_q;
    assign vertex_out    = s3_pos_q;
    assign color_out     = s3_col_q;
    assign clamped_out   = s3_clamp_q;
    assign count_out     = count_q;

endmodule

// File: tb/tb_viewport_transform.sv
// Scoreboard bench for viewport_transform; expected vertices come from an
// arithmetic model of the screen mapping (VIEWPORT_CLAMP_EN-aware).
module tb_viewport_transform;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         flush_in;
    logic         valid_in;
    logic         ready_out;
    logic [15:0]  vertex_id_in;
    logic [95:0]  vertex_in;
    logic [11:0]  color_in;
    logic         valid_out;
    logic         ready_in;
    logic [15:0]  vertex_id_out;
    logic [127:0] vertex_out;
    logic [11:0]  color_out;
    logic         clamped_out;
    logic [15:0]  count_out;

    viewport_transform dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (flush_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .vertex_id_in  (vertex_id_in),
        .vertex_in     (vertex_in),
        .color_in      (color_in),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .vertex_id_out (vertex_id_out),
        .vertex_out    (vertex_out),
        .color_out     (color_out),
        .clamped_out   (clamped_out),
        .count_out     (count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0]  id;
        logic [127:0] v;
        logic [11:0]  c;
        logic         cl;
    } exp_t;

    exp_t         sb_q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_out = 0;
    int           cnt_model = 0;
    bit           started = 0;
    bit           stall_prev = 0;
    logic [15:0]  prev_id;
    logic [127:0] prev_vo;
    bit           rnd_done;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Screen mapping: x*160+160, 120-y*120, z*128+128 in Q16.16, wrapped to 32 bits.
    function automatic logic [31:0] map_lane(input logic [31:0] v,
                                             input longint scale,
                                             input longint off);
        longint r;
        r = longint'($signed(v)) * scale + off * 65536;
        return r[31:0];
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v, input int hi,
                                        inout logic hit);
`ifdef VIEWPORT_CLAMP_EN
        int s;
        s = int'(v);
        if (s < 0) begin
            hit = 1'b1;
            return 32'd0;
        end
        if (s > hi * 65536) begin
            hit = 1'b1;
            return 32'(hi * 65536);
        end
`else
        if (hi < 0) hit = 1'b1;
`endif
        return v;
    endfunction

    function automatic exp_t model(input logic [15:0] id, input logic [95:0] v,
                                   input logic [11:0] c);
        exp_t e;
        logic hit;
        logic [31:0] x, y, z;
        hit = 1'b0;
        x = sat(map_lane(v[31:0], 160, 160), 319, hit);
        y = sat(map_lane(v[63:32], -120, 120), 239, hit);
        z = sat(map_lane(v[95:64], 128, 128), 255, hit);
        e.id = id;
        e.v  = {32'h0001_0000, z, y, x};
        e.c  = c;
        e.cl = hit;
        return e;
    endfunction

    always @(negedge clk_in) begin
        if (started) begin
            exp_t e;
            chk("ready_out", 128'(ready_out),
                128'((!valid_out || ready_in) && !flush_in));
            chk("count_out", 128'(count_out), 128'(16'(cnt_model)));
            if (stall_prev) begin
                chk("stall_valid", 128'(valid_out), 128'(1));
                chk("stall_data", vertex_out, prev_vo);
                chk("stall_id", 128'(vertex_id_out), 128'(prev_id));
            end
            if (rst_in && valid_out && ready_in) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 128'(sb_q.size()), 128'(1));
                end else begin
                    e = sb_q.pop_front();
                    chk("out_vertex", vertex_out, e.v);
                    chk("out_id", 128'(vertex_id_out), 128'(e.id));
                    chk("out_color", 128'(color_out), 128'(e.c));
                    chk("out_clamped", 128'(clamped_out), 128'(e.cl));
                end
                n_out++;
            end
            stall_prev = rst_in && !flush_in && valid_out && !ready_in;
            prev_id = vertex_id_out;
            prev_vo = vertex_out;
            if (!rst_in) begin
                sb_q.delete();
                cnt_model = 0;
                n_out = 0;
            end else if (flush_in) begin
                sb_q.delete();
                cnt_model = 0;
            end else if (valid_in && ready_out) begin
                sb_q.push_back(model(vertex_id_in, vertex_in, color_in));
                cnt_model = (cnt_model + 1) % 65536;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [15:0] id, input logic [95:0] v,
                        input logic [11:0] c);
        bit acc;
        acc = 1'b0;
        valid_in = 1'b1;
        vertex_id_in = id;
        vertex_in = v;
        color_in = c;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk_in);
            acc = ready_out;
            step();
        end
        valid_in = 1'b0;
        if (!acc) chk("send_timeout", 128'(acc), 128'(1));
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) step();
        chk("drain_empty", 128'(sb_q.size()), 128'(0));
    endtask

    function automatic logic [31:0] rnd_lane();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h0003_0000)) - 32'h0001_8000;
    endfunction

    initial begin
        int lat;
        int n_before;
        rst_in = 1'b0;
        flush_in = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        vertex_id_in = '0;
        vertex_in = '0;
        color_in = '0;
        repeat (2) step();
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_valid", 128'(valid_out), 128'(0));
        chk("rst_vertex", vertex_out, 128'(0));
        chk("rst_id", 128'(vertex_id_out), 128'(0));
        chk("rst_color", 128'(color_out), 128'(0));
        chk("rst_clamped", 128'(clamped_out), 128'(0));
        chk("rst_count", 128'(count_out), 128'(0));
        chk("rst_ready", 128'(ready_out), 128'(1));
        started = 1'b1;
        step();

        // Origin maps to screen centre; check latency too.
        ready_in = 1'b1;
        send(16'h0001, 96'd0, 12'h123);
        lat = 0;
        for (int i = 0; i < 10 && !valid_out; i++) begin
            @(negedge clk_in);
            lat++;
        end
        chk("latency", 128'(lat), 128'(3));
        chk("origin", vertex_out,
            {32'h0001_0000, 32'h0080_0000, 32'h0078_0000, 32'h00A0_0000});
        chk("origin_clamp", 128'(clamped_out), 128'(0));
        step();

        send(16'h0002, {32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000}, 12'h456);
        for (int i = 0; i < 10 && !valid_out; i++) @(negedge clk_in);
        chk("corner", vertex_out, {32'h0001_0000, 96'd0});
        chk("corner_clamp", 128'(clamped_out), 128'(0));
        step();

        send(16'h0003, {32'h0001_0000, 32'h0000_0000, 32'h0002_0000}, 12'h789);
        for (int i = 0; i < 10 && !valid_out; i++) @(negedge clk_in);
`ifdef VIEWPORT_CLAMP_EN
        chk("over_x", 128'(vertex_out[31:0]), 128'(32'h013F_0000));
        chk("over_z", 128'(vertex_out[95:64]), 128'(32'h00FF_0000));
        chk("over_clamp", 128'(clamped_out), 128'(1));
`else
        chk("over_x", 128'(vertex_out[31:0]), 128'(32'h01E0_0000));
        chk("over_z", 128'(vertex_out[95:64]), 128'(32'h0100_0000));
        chk("over_clamp", 128'(clamped_out), 128'(0));
`endif
        step();
        drain();

        // Eight back-to-back vertices with a 4-cycle downstream stall.
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(i), {rnd_lane(), rnd_lane(), rnd_lane()},
                         12'($urandom));
            end
            begin
                repeat (3) step();
                ready_in = 1'b0;
                repeat (4) step();
                ready_in = 1'b1;
            end
        join
        drain();
        @(negedge clk_in);
        chk("burst_count", 128'(count_out), 128'(8));
        chk("burst_nout", 128'(n_out), 128'(8));
        step();

        // Flush with three vertices parked in the pipe.
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++)
            send(16'(16'h0040 + i), {rnd_lane(), rnd_lane(), rnd_lane()},
                 12'($urandom));
        n_before = n_out;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk_in);
        chk("flush_valid", 128'(valid_out), 128'(0));
        chk("flush_count", 128'(count_out), 128'(0));
        repeat (6) step();
        chk("flush_no_emit", 128'(n_out), 128'(n_before));

        // Reset while an output is stalled.
        ready_in = 1'b0;
        send(16'h0050, {rnd_lane(), rnd_lane(), rnd_lane()}, 12'hABC);
        repeat (3) step();
        @(negedge clk_in);
        chk("pre_rst_valid", 128'(valid_out), 128'(1));
        step();
        do_reset();
        @(negedge clk_in);
        chk("mrst_valid", 128'(valid_out), 128'(0));
        chk("mrst_vertex", vertex_out, 128'(0));
        chk("mrst_id", 128'(vertex_id_out), 128'(0));
        chk("mrst_color", 128'(color_out), 128'(0));
        chk("mrst_count", 128'(count_out), 128'(0));
        chk("mrst_ready", 128'(ready_out), 128'(1));
        step();
        ready_in = 1'b1;

        // Randomized traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send(16'(i + 100), {rnd_lane(), rnd_lane(), rnd_lane()},
                         12'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    ready_in = ($urandom_range(0, 9) < 7);
                    step();
                end
                ready_in = 1'b1;
            end
        join
        drain();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
